// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_BYTE_W = 2 * DIGIT_W;
  localparam int unsigned BEEP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_SEC_TENS = 4'd5;

  // True when both bytes are legal BCD and seconds stay within 00..59.
  function automatic logic bcd_time_valid(input logic [BCD_BYTE_W-1:0] min,
                                          input logic [BCD_BYTE_W-1:0] sec);
    return (min[7:4] <= BCD_MAX_UNITS) && (min[3:0] <= BCD_MAX_UNITS) &&
           (sec[7:4] <= BCD_MAX_SEC_TENS) && (sec[3:0] <= BCD_MAX_UNITS);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One loadable BCD down-counting digit; wraps to MAX and flags a borrow.
module bcd_digit_down
  import countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_UNITS
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_val,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_borrow_c
);

  logic [DIGIT_W-1:0] r_digit;

  // Digit register: load has priority over a decrement step.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_en) begin
      r_digit <= (r_digit == '0) ? MAX : r_digit - DIGIT_W'(1);
    end
  end

  assign o_digit    = r_digit;
  assign o_borrow_c = i_en && (r_digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable BCD mm:ss countdown timer with expiry and timed beep output.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned BEEP_SECONDS = 10
) (
  input  logic                  i_sysclk,
  input  logic                  i_reset_n,
  input  logic                  i_1hz_stb,
  input  logic                  i_load,
  input  logic [BCD_BYTE_W-1:0] i_load_min,
  input  logic [BCD_BYTE_W-1:0] i_load_sec,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_clear,
  output logic [BCD_BYTE_W-1:0] o_min,
  output logic [BCD_BYTE_W-1:0] o_sec,
  output logic                  o_running,
  output logic                  o_expired,
  output logic                  o_beep,
  output logic                  o_load_err
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_running;
  logic                    r_expired;
  logic                    r_beep;
  logic                    w_beep_nxt;
  logic                    r_load_err;
  logic                    w_load_err_nxt;
  logic [BEEP_CNT_W-1:0]   r_beep_cnt;
  logic [BEEP_CNT_W-1:0]   w_beep_cnt_nxt;

  logic                    w_dec;
  logic                    w_dig_load_req;
  logic                    w_dig_zero_req;
  logic                    w_dig_load;
  logic [2*BCD_BYTE_W-1:0] w_dig_val;
  logic                    w_bor_su;
  logic                    w_bor_st;
  logic                    w_bor_mu;
  logic                    w_bor_mt;
  logic [BCD_BYTE_W-1:0]   w_min;
  logic [BCD_BYTE_W-1:0]   w_sec;
  logic                    w_count_zero;
  logic                    w_count_one;
  logic                    w_load_ok;

  assign w_count_zero = (w_min == '0) && (w_sec == '0);
  assign w_count_one  = (w_min == '0) && (w_sec == BCD_BYTE_W'(1));
  assign w_load_ok    = bcd_time_valid(i_load_min, i_load_sec);

  // A borrow out of the minutes tens digit would mean counting below 00:00: pin to zero.
  assign w_dig_load = w_dig_load_req | w_bor_mt;
  assign w_dig_val  = (w_dig_zero_req | w_bor_mt) ? '0 : {i_load_min, i_load_sec};

  bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_sec_units (
    .i_clk(i_sysclk), .i_reset_n(i_reset_n), .i_en(w_dec), .i_load(w_dig_load),
    .i_load_val(w_dig_val[3:0]), .o_digit(w_sec[3:0]), .o_borrow_c(w_bor_su));

  bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
    .i_clk(i_sysclk), .i_reset_n(i_reset_n), .i_en(w_bor_su), .i_load(w_dig_load),
    .i_load_val(w_dig_val[7:4]), .o_digit(w_sec[7:4]), .o_borrow_c(w_bor_st));

  bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_min_units (
    .i_clk(i_sysclk), .i_reset_n(i_reset_n), .i_en(w_bor_st), .i_load(w_dig_load),
    .i_load_val(w_dig_val[11:8]), .o_digit(w_min[3:0]), .o_borrow_c(w_bor_mu));

  bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_min_tens (
    .i_clk(i_sysclk), .i_reset_n(i_reset_n), .i_en(w_bor_mu), .i_load(w_dig_load),
    .i_load_val(w_dig_val[15:12]), .o_digit(w_min[7:4]), .o_borrow_c(w_bor_mt));

  // State and status registers.
  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_beep     <= 1'b0;
      r_load_err <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_expired  <= (w_state_nxt == EXPIRED);
      r_beep     <= w_beep_nxt;
      r_load_err <= w_load_err_nxt;
      r_beep_cnt <= w_beep_cnt_nxt;
    end
  end

  // Command decode in priority order: clear > load > pause > start > strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_beep_nxt     = r_beep;
    w_beep_cnt_nxt = r_beep_cnt;
    w_load_err_nxt = 1'b0;
    w_dig_load_req = 1'b0;
    w_dig_zero_req = 1'b0;
    w_dec          = 1'b0;

    if (i_clear) begin
      w_state_nxt    = IDLE;
      w_dig_load_req = 1'b1;
      w_dig_zero_req = 1'b1;
      w_beep_nxt     = 1'b0;
      w_beep_cnt_nxt = '0;
    end else if (i_load) begin
      if (r_state != RUN) begin
        if (w_load_ok) begin
          w_state_nxt    = IDLE;
          w_dig_load_req = 1'b1;
          w_beep_nxt     = 1'b0;
          w_beep_cnt_nxt = '0;
        end else begin
          w_load_err_nxt = 1'b1;
        end
      end
    end else if (i_pause) begin
      if (r_state == RUN) begin
        w_state_nxt = PAUSE;
      end
    end else if (i_start) begin
      if ((r_state == PAUSE) || ((r_state == IDLE) && !w_count_zero)) begin
        w_state_nxt = RUN;
      end
    end else if (i_1hz_stb) begin
      case (r_state)
        RUN: begin
          w_dec = 1'b1;
          if (w_count_one) begin
            w_state_nxt    = EXPIRED;
            w_beep_nxt     = 1'b1;
            w_beep_cnt_nxt = BEEP_CNT_W'(BEEP_SECONDS);
          end
        end
        EXPIRED: begin
          if (r_beep_cnt != '0) begin
            w_beep_cnt_nxt = r_beep_cnt - BEEP_CNT_W'(1);
            if (r_beep_cnt == BEEP_CNT_W'(1)) begin
              w_beep_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_min      = w_min;
  assign o_sec      = w_sec;
  assign o_running  = r_running;
  assign o_expired  = r_expired;
  assign o_beep     = r_beep;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table plus multi-cycle sequences, scoreboard-checked.
module tb_countdown_timer;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RST  = 6'b100000;
  localparam logic [5:0] C_CLR  = 6'b010000;
  localparam logic [5:0] C_LD   = 6'b001000;
  localparam logic [5:0] C_ST   = 6'b000100;
  localparam logic [5:0] C_PA   = 6'b000010;
  localparam logic [5:0] C_STB  = 6'b000001;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1000;
  localparam logic [3:0] F_EXP  = 4'b0100;
  localparam logic [3:0] F_BEEP = 4'b0010;
  localparam logic [3:0] F_ERR  = 4'b0001;

  typedef struct {
    logic [5:0] cmd;
    logic [7:0] lmin;
    logic [7:0] lsec;
    logic [7:0] emin;
    logic [7:0] esec;
    logic [3:0] eflags;
  } vec_t;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_1hz_stb = 1'b0;
  logic       i_load = 1'b0;
  logic [7:0] i_load_min = 8'h00;
  logic [7:0] i_load_sec = 8'h00;
  logic       i_start = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_clear = 1'b0;
  logic [7:0] o_min;
  logic [7:0] o_sec;
  logic       o_running;
  logic       o_expired;
  logic       o_beep;
  logic       o_load_err;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  countdown_timer #(.BEEP_SECONDS(3)) dut (
    .i_sysclk(clk), .i_reset_n(i_reset_n), .i_1hz_stb(i_1hz_stb),
    .i_load(i_load), .i_load_min(i_load_min), .i_load_sec(i_load_sec),
    .i_start(i_start), .i_pause(i_pause), .i_clear(i_clear),
    .o_min(o_min), .o_sec(o_sec), .o_running(o_running), .o_expired(o_expired),
    .o_beep(o_beep), .o_load_err(o_load_err));

  function automatic vec_t mk(input logic [5:0] cmd, input logic [7:0] lmin,
                              input logic [7:0] lsec, input logic [7:0] emin,
                              input logic [7:0] esec, input logic [3:0] eflags);
    vec_t v;
    v.cmd = cmd; v.lmin = lmin; v.lsec = lsec;
    v.emin = emin; v.esec = esec; v.eflags = eflags;
    return v;
  endfunction

  // Seconds remaining -> BCD {min, sec}.
  function automatic logic [15:0] to_mmss(input int unsigned t);
    int unsigned m;
    int unsigned s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic check(input string tag);
    vec_t e;
    logic [19:0] got;
    logic [19:0] want;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      got  = {o_min, o_sec, o_running, o_expired, o_beep, o_load_err};
      want = {e.emin, e.esec, e.eflags};
      if (got !== want) begin
        n_errors++;
        $display("FAIL %s: got %h:%h run/exp/beep/err=%b, want %h:%h %b",
                 tag, got[19:12], got[11:4], got[3:0], want[19:12], want[11:4], want[3:0]);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample after the edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    i_reset_n  = ~t.cmd[5];
    i_clear    = t.cmd[4];
    i_load     = t.cmd[3];
    i_start    = t.cmd[2];
    i_pause    = t.cmd[1];
    i_1hz_stb  = t.cmd[0];
    i_load_min = t.lmin;
    i_load_sec = t.lsec;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    logic [15:0] mm;

    // Reset, borrow across minutes, bad load, pause/start with strobe, expiry and beep.
    tbl.push_back(mk(C_RST,         8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_LD,          8'h10, 8'h00, 8'h10, 8'h00, F_NONE));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h10, 8'h00, F_RUN));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h09, 8'h59, F_RUN));
    tbl.push_back(mk(C_CLR,         8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_LD,          8'h12, 8'h6A, 8'h00, 8'h00, F_ERR));
    tbl.push_back(mk(C_NONE,        8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_LD,          8'h00, 8'h03, 8'h00, 8'h03, F_NONE));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h00, 8'h03, F_RUN));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h02, F_RUN));
    tbl.push_back(mk(C_PA | C_STB,  8'h00, 8'h00, 8'h00, 8'h02, F_NONE));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(C_STB,       8'h00, 8'h00, 8'h00, 8'h02, F_NONE));
    tbl.push_back(mk(C_ST | C_STB,  8'h00, 8'h00, 8'h00, 8'h02, F_RUN));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h01, F_RUN));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_EXP | F_BEEP));
    tbl.push_back(mk(C_NONE,        8'h00, 8'h00, 8'h00, 8'h00, F_EXP | F_BEEP));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_EXP | F_BEEP));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_EXP | F_BEEP));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_EXP));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_EXP));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h00, 8'h00, F_EXP));
    tbl.push_back(mk(C_LD,          8'h99, 8'h60, 8'h00, 8'h00, F_EXP | F_ERR));
    tbl.push_back(mk(C_CLR,         8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    // Priority: load beats start, clear beats load, load ignored (no error) in RUN.
    tbl.push_back(mk(C_LD,          8'h00, 8'h40, 8'h00, 8'h40, F_NONE));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h00, 8'h40, F_RUN));
    tbl.push_back(mk(C_LD,          8'h05, 8'h00, 8'h00, 8'h40, F_RUN));
    tbl.push_back(mk(C_LD | C_PA,   8'h5A, 8'h00, 8'h00, 8'h40, F_RUN));
    tbl.push_back(mk(C_PA,          8'h00, 8'h00, 8'h00, 8'h40, F_NONE));
    tbl.push_back(mk(C_LD | C_ST,   8'h02, 8'h00, 8'h02, 8'h00, F_NONE));
    tbl.push_back(mk(C_CLR | C_LD,  8'h07, 8'h00, 8'h00, 8'h00, F_NONE));
    // Reset asserted while running at 00:40; strobes afterwards change nothing.
    tbl.push_back(mk(C_LD,          8'h00, 8'h40, 8'h00, 8'h40, F_NONE));
    tbl.push_back(mk(C_ST,          8'h00, 8'h00, 8'h00, 8'h40, F_RUN));
    tbl.push_back(mk(C_RST | C_STB, 8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_NONE));
    tbl.push_back(mk(C_STB,         8'h00, 8'h00, 8'h00, 8'h00, F_NONE));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Full run from 01:05 through expiry, with idle gaps between some strobes.
    apply(mk(C_LD, 8'h01, 8'h05, 8'h01, 8'h05, F_NONE), "run65_load");
    apply(mk(C_ST, 8'h00, 8'h00, 8'h01, 8'h05, F_RUN), "run65_start");
    for (int k = 1; k <= 65; k++) begin
      mm = to_mmss(int'(65 - k));
      apply(mk(C_STB, 8'h00, 8'h00, mm[15:8], mm[7:0],
               (k == 65) ? (F_EXP | F_BEEP) : F_RUN), $sformatf("run65_stb%0d", k));
      if (k % 16 == 0)
        apply(mk(C_NONE, 8'h00, 8'h00, mm[15:8], mm[7:0], F_RUN), $sformatf("run65_gap%0d", k));
    end
    apply(mk(C_STB, 8'h00, 8'h00, 8'h00, 8'h00, F_EXP | F_BEEP), "exp_stb1");
    // Valid load while expired clears expiry and beep.
    apply(mk(C_LD,  8'h00, 8'h07, 8'h00, 8'h07, F_NONE), "exp_reload");
    apply(mk(C_STB, 8'h00, 8'h00, 8'h00, 8'h07, F_NONE), "idle_stb");

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
